// File: rtl/ethernet_udp_receive.sv
// ethernet_udp_receive: MII receiver that oversamples the PHY nibble bus, parses Ethernet II/IPv4/UDP,
// filters on local MAC/IP/port, checks the FCS and strobes out a fixed-size payload.
module ethernet_udp_receive #(
    parameter int DATA_BYTES       = 16,
    parameter bit ACCEPT_BROADCAST = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    eth_rx_clk,
    input  logic                    eth_rx_dv,
    input  logic [3:0]              eth_rx_d,
    input  logic [47:0]             local_mac,
    input  logic [31:0]             local_ip,
    input  logic [15:0]             local_port,
    output logic [8*DATA_BYTES-1:0] data,
    output logic [47:0]             src_mac,
    output logic [31:0]             src_ip,
    output logic [15:0]             src_port,
    output logic                    valid,
    output logic                    drop
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, WAIT_END} state_t;
    localparam int PW = 8*DATA_BYTES;
    localparam logic [10:0] HDR_END = 11'd41;
    localparam logic [10:0] PAY_END = 11'(41 + DATA_BYTES);
    localparam logic [10:0] MIN_LEN = 11'(46 + DATA_BYTES);
    localparam logic [10:0] MAX_LEN = 11'd1522;

    logic [1:0]       rxc_q, dv_q;
    logic [1:0][3:0]  d_q;
    logic             rxc_p_q, dvp_q, ph_q, rej_q;
    logic [3:0]       lo_q;
    state_t           st_q;
    logic [31:0]      crc_q, crc_d;
    logic [10:0]      cnt_q;
    logic [335:0]     hdr_q, hdr_d;
    logic [PW-1:0]    pay_q, data_q;
    logic [47:0]      src_mac_q;
    logic [31:0]      src_ip_q;
    logic [15:0]      src_port_q;
    logic             valid_q, drop_q;
    logic             samp, rise, fall, byte_v, hdr_ok, good;
    logic [7:0]       byte_d;

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    always_comb begin
        samp   = rxc_q[1] & ~rxc_p_q;
        rise   = samp & dv_q[1] & ~dvp_q;
        fall   = samp & ~dv_q[1] & dvp_q;
        byte_v = samp & dv_q[1] & dvp_q & ph_q;
        byte_d = {d_q[1], lo_q};
        crc_d  = crc8(crc_q, byte_d);
        // Header is shifted in MSB-first, so offset k lands at [8*(41-k)+:8]
        hdr_d  = {hdr_q[327:0], byte_d};
        hdr_ok = (hdr_d[335:288] == local_mac || (ACCEPT_BROADCAST && &hdr_d[335:288]))
                 && hdr_d[239:224] == 16'h0800 && hdr_d[223:216] == 8'h45
                 && hdr_d[151:144] == 8'h11 && hdr_d[95:64] == local_ip
                 && hdr_d[47:32] == local_port && hdr_d[31:16] == 16'(8 + DATA_BYTES);
        // Residue 0xC704DD7B appears bit-reversed in the reflected register
        good   = cnt_q >= MIN_LEN && cnt_q <= MAX_LEN && crc_q == 32'hDEBB20E3 && !rej_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxc_q      <= '0;
            dv_q       <= '0;
            d_q        <= '0;
            rxc_p_q    <= 1'b0;
            dvp_q      <= 1'b1;
            ph_q       <= 1'b0;
            lo_q       <= '0;
            st_q       <= IDLE;
            crc_q      <= '1;
            cnt_q      <= '0;
            rej_q      <= 1'b0;
            hdr_q      <= '0;
            pay_q      <= '0;
            data_q     <= '0;
            src_mac_q  <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            rxc_q   <= {rxc_q[0], eth_rx_clk};
            dv_q    <= {dv_q[0], eth_rx_dv};
            d_q     <= {d_q[0], eth_rx_d};
            rxc_p_q <= rxc_q[1];
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            if (samp) begin
                dvp_q <= dv_q[1];
                if (dv_q[1]) begin
                    ph_q <= rise | ~ph_q;
                    if (rise || !ph_q) lo_q <= d_q[1];
                end
            end
            if (byte_v && st_q inside {HEADER, PAYLOAD, TRAILER}) begin
                crc_q <= crc_d;
                cnt_q <= cnt_q + 11'(cnt_q != '1);
            end
            case (st_q)
                IDLE:     if (rise) st_q <= PREAMBLE;
                PREAMBLE: if (fall) st_q <= IDLE;
                          else if (byte_v && byte_d != 8'h55) begin
                              st_q  <= byte_d == 8'hD5 ? HEADER : WAIT_END;
                              crc_q <= '1;
                              cnt_q <= '0;
                              rej_q <= 1'b0;
                          end
                HEADER:   if (byte_v) begin
                              hdr_q <= hdr_d;
                              if (cnt_q == HDR_END) begin
                                  st_q  <= PAYLOAD;
                                  rej_q <= ~hdr_ok;
                              end
                          end
                PAYLOAD:  if (byte_v) begin
                              pay_q <= {byte_d, pay_q[PW-1:8]};
                              if (cnt_q == PAY_END) st_q <= TRAILER;
                          end
                WAIT_END: if (fall) st_q <= IDLE;
                default:  ;
            endcase
            if (fall && st_q inside {HEADER, PAYLOAD, TRAILER}) begin
                st_q    <= IDLE;
                valid_q <= st_q == TRAILER && good;
                drop_q  <= !(st_q == TRAILER && good);
                if (st_q == TRAILER && good) begin
                    data_q     <= pay_q;
                    src_mac_q  <= hdr_q[287:240];
                    src_ip_q   <= hdr_q[127:96];
                    src_port_q <= hdr_q[63:48];
                end
            end
        end
    end

    assign data     = data_q;
    assign src_mac  = src_mac_q;
    assign src_ip   = src_ip_q;
    assign src_port = src_port_q;
    assign valid    = valid_q;
    assign drop     = drop_q;
endmodule

// File: tb/tb_ethernet_udp_receive.sv
// tb_ethernet_udp_receive: directed MII frames against a broadcast-accepting and a broadcast-rejecting receiver.
module tb_ethernet_udp_receive;
    localparam int DB = 16;
    logic clk = 0, reset = 1, eth_rx_clk = 0, eth_rx_dv = 0;
    logic [3:0]  eth_rx_d = 0;
    logic [47:0] local_mac = 48'h1a2b3c4d5e6f;
    logic [31:0] local_ip = 32'h11223344;
    logic [15:0] local_port = 16'h1000;
    logic [8*DB-1:0] data, data_b;
    logic [47:0] src_mac, src_mac_b;
    logic [31:0] src_ip, src_ip_b;
    logic [15:0] src_port, src_port_b;
    logic valid, drop, valid_b, drop_b;
    int checks = 0, errors = 0;
    int vcnt = 0, dcnt = 0, vcnt_b = 0, dcnt_b = 0, both = 0;
    logic [7:0] fr[$];

    ethernet_udp_receive #(.DATA_BYTES(DB), .ACCEPT_BROADCAST(1'b1)) dut (
        .clk(clk), .reset(reset), .eth_rx_clk(eth_rx_clk), .eth_rx_dv(eth_rx_dv), .eth_rx_d(eth_rx_d),
        .local_mac(local_mac), .local_ip(local_ip), .local_port(local_port),
        .data(data), .src_mac(src_mac), .src_ip(src_ip), .src_port(src_port), .valid(valid), .drop(drop));

    ethernet_udp_receive #(.DATA_BYTES(DB), .ACCEPT_BROADCAST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .eth_rx_clk(eth_rx_clk), .eth_rx_dv(eth_rx_dv), .eth_rx_d(eth_rx_d),
        .local_mac(local_mac), .local_ip(local_ip), .local_port(local_port),
        .data(data_b), .src_mac(src_mac_b), .src_ip(src_ip_b), .src_port(src_port_b), .valid(valid_b), .drop(drop_b));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) vcnt++;
        if (drop) dcnt++;
        if (valid_b) vcnt_b++;
        if (drop_b) dcnt_b++;
        if (valid && drop) both++;
    end

    function automatic logic [8*DB-1:0] pat(input logic [7:0] base);
        logic [8*DB-1:0] p;
        for (int i = 0; i < DB; i++) p[8*i+:8] = base + 8'(i);
        return p;
    endfunction

    function automatic logic [31:0] crc_calc(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fr[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return c;
    endfunction

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fr.push_back(v[8*i+:8]);
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] dport, input logic [7:0] base, input bit flip);
        logic [31:0] fcs;
        fr = {};
        push_be(dmac, 6);
        push_be(48'haabbccddeeff, 6);
        push_be(48'h0800_4500_002C, 6);
        push_be(48'h0000_0000_4011, 6);
        push_be(48'h0000, 2);
        push_be(48'h55667788, 4);
        push_be(48'h11223344, 4);
        push_be(48'h1000, 2);
        push_be({32'd0, dport}, 2);
        push_be(48'h0018_0000, 4);
        for (int i = 0; i < DB; i++) fr.push_back(base + 8'(i));
        push_be(48'h0000, 2);
        fcs = ~crc_calc(fr.size());
        for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i+:8]);
        if (flip) fr[45] = fr[45] ^ 8'h04;
    endtask

    task automatic nib(input logic dv, input logic [3:0] d);
        eth_rx_dv = dv;
        eth_rx_d = d;
        #20 eth_rx_clk = 1;
        #20 eth_rx_clk = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) nib(1'b0, 4'h0);
    endtask

    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            nib(1'b1, fr[i][3:0]);
            nib(1'b1, fr[i][7:4]);
        end
    endtask

    task automatic preamble(input logic [7:0] sfd);
        repeat (14) nib(1'b1, 4'h5);
        nib(1'b1, sfd[3:0]);
        nib(1'b1, sfd[7:4]);
    endtask

    task automatic send(input logic [7:0] sfd, input int nbytes, input bit odd);
        vcnt = 0; dcnt = 0; vcnt_b = 0; dcnt_b = 0;
        preamble(sfd);
        send_bytes(0, nbytes);
        if (odd) nib(1'b1, 4'hA);
        idle(24);
    endtask

    task automatic test_reset;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", drop); end
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
        checks++; if ({src_mac, src_ip, src_port} !== '0) begin errors++; $display("FAIL reset_src got %h %h %h want 0", src_mac, src_ip, src_port); end
    endtask

    task automatic test_good;
        build(local_mac, 16'h1000, 8'h00, 1'b0);
        send(8'hD5, fr.size(), 1'b0);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL good_valid_count got %0d want 1", vcnt); end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL good_drop_count got %0d want 0", dcnt); end
        checks++; if (data !== pat(8'h00)) begin errors++; $display("FAIL good_data got %h want %h", data, pat(8'h00)); end
        checks++; if (src_mac !== 48'haabbccddeeff) begin errors++; $display("FAIL good_src_mac got %h want aabbccddeeff", src_mac); end
        checks++; if (src_ip !== 32'h55667788) begin errors++; $display("FAIL good_src_ip got %h want 55667788", src_ip); end
        checks++; if (src_port !== 16'h1000) begin errors++; $display("FAIL good_src_port got %h want 1000", src_port); end
        checks++; if (vcnt_b !== 1) begin errors++; $display("FAIL good_valid_b got %0d want 1", vcnt_b); end
    endtask

    task automatic test_port;
        build(local_mac, 16'h1001, 8'h77, 1'b0);
        send(8'hD5, fr.size(), 1'b0);
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL port_drop got %0d want 1", dcnt); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL port_valid got %0d want 0", vcnt); end
        checks++; if (data !== pat(8'h00)) begin errors++; $display("FAIL port_data_held got %h want %h", data, pat(8'h00)); end
    endtask

    task automatic test_fcs;
        build(local_mac, 16'h1000, 8'h00, 1'b1);
        send(8'hD5, fr.size(), 1'b0);
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL fcs_drop got %0d want 1", dcnt); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL fcs_valid got %0d want 0", vcnt); end
        build(local_mac, 16'h1000, 8'hF0, 1'b0);
        send(8'hD5, fr.size(), 1'b0);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL fcs_next_valid got %0d want 1", vcnt); end
        checks++; if (data[7:0] !== 8'hF0) begin errors++; $display("FAIL fcs_next_byte0 got %h want f0", data[7:0]); end
        checks++; if (data !== pat(8'hF0)) begin errors++; $display("FAIL fcs_next_data got %h want %h", data, pat(8'hF0)); end
    endtask

    task automatic test_broadcast;
        build(48'hffffffffffff, 16'h1000, 8'h10, 1'b0);
        send(8'hD5, fr.size(), 1'b0);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL bcast_valid got %0d want 1", vcnt); end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL bcast_drop got %0d want 0", dcnt); end
        checks++; if (vcnt_b !== 0) begin errors++; $display("FAIL bcast_off_valid got %0d want 0", vcnt_b); end
        checks++; if (dcnt_b !== 1) begin errors++; $display("FAIL bcast_off_drop got %0d want 1", dcnt_b); end
        checks++; if (data !== pat(8'h10)) begin errors++; $display("FAIL bcast_data got %h want %h", data, pat(8'h10)); end
    endtask

    task automatic test_bad_sfd;
        build(local_mac, 16'h1000, 8'h60, 1'b0);
        send(8'h57, fr.size(), 1'b0);
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL sfd_valid got %0d want 0", vcnt); end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL sfd_drop got %0d want 0", dcnt); end
    endtask

    task automatic test_back_to_back;
        build(local_mac, 16'h1000, 8'h20, 1'b0);
        send(8'hD5, 48, 1'b0);
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL trunc_drop got %0d want 1", dcnt); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL trunc_valid got %0d want 0", vcnt); end
        build(local_mac, 16'h1000, 8'h30, 1'b0);
        send(8'hD5, fr.size(), 1'b0);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL b2b_valid got %0d want 1", vcnt); end
        checks++; if (data !== pat(8'h30)) begin errors++; $display("FAIL b2b_data got %h want %h", data, pat(8'h30)); end
    endtask

    task automatic test_reset_mid;
        build(local_mac, 16'h1000, 8'h40, 1'b0);
        vcnt = 0; dcnt = 0;
        preamble(8'hD5);
        send_bytes(0, 20);
        reset = 1;
        #1;
        checks++; if (data !== '0) begin errors++; $display("FAIL rstmid_data got %h want 0", data); end
        checks++; if ({src_mac, src_ip, src_port} !== '0) begin errors++; $display("FAIL rstmid_src got %h %h %h want 0", src_mac, src_ip, src_port); end
        checks++; if ({valid, drop} !== 2'b00) begin errors++; $display("FAIL rstmid_strobes got %b want 00", {valid, drop}); end
        #19 reset = 0;
        send_bytes(20, fr.size());
        idle(24);
        checks++; if (vcnt + dcnt !== 0) begin errors++; $display("FAIL rstmid_tail got %0d strobes want 0", vcnt + dcnt); end
        build(local_mac, 16'h1000, 8'h50, 1'b0);
        send(8'hD5, fr.size(), 1'b1);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL rstmid_next_valid got %0d want 1", vcnt); end
        checks++; if (data !== pat(8'h50)) begin errors++; $display("FAIL rstmid_next_data got %h want %h", data, pat(8'h50)); end
        checks++; if (src_ip !== 32'h55667788) begin errors++; $display("FAIL rstmid_next_src_ip got %h want 55667788", src_ip); end
        checks++; if (both !== 0) begin errors++; $display("FAIL valid_drop_overlap got %0d want 0", both); end
    endtask

    initial begin
        idle(4);
        reset = 0;
        idle(4);
        test_reset;
        test_good;
        test_port;
        test_fcs;
        test_broadcast;
        test_bad_sfd;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ethernet_udp_receive.md
Name: ethernet_udp_receive

Overview:
MII receive-side counterpart of ethernet_udp_transmit. Oversamples the PHY's 4-bit MII receive bus in the system clock domain and assembles bytes. Parses Ethernet II, IPv4 and UDP headers, filters on local MAC/IP/port and checks the FCS. Delivers a fixed-size UDP payload plus sender identity with a one-cycle valid strobe.

Parameters:
DATA_BYTES, 16, payload bytes per accepted datagram; UDP length must equal 8+DATA_BYTES.
ACCEPT_BROADCAST, 1, when 1, also accept dest MAC ff:ff:ff:ff:ff:ff.

Ports:
clk  in  1  system clock, ≥4x eth_rx_clk (100 MHz nominal).
reset  in  1  asynchronous, active-high reset.
eth_rx_clk  in  1  PHY receive clock (25 MHz), treated as data and synchronized.
eth_rx_dv  in  1  MII receive data valid.
eth_rx_d  in  4  MII receive nibble, low nibble first.
local_mac  in  48  MAC this node answers to.
local_ip  in  32  IPv4 address this node answers to.
local_port  in  16  UDP destination port accepted.
data  out  8*DATA_BYTES  last accepted payload; payload byte i at data[8*i+:8].
src_mac  out  48  sender MAC of last accepted frame.
src_ip  out  32  sender IP of last accepted frame.
src_port  out  16  sender UDP port of last accepted frame.
valid  out  1  one-cycle strobe: data/src_* updated.
drop  out  1  one-cycle strobe: frame discarded.

Behaviour:
- Reset: all outputs 0, FSM IDLE, CRC = 0xFFFFFFFF, sync chain cleared.
- Input sync: eth_rx_clk, eth_rx_dv and eth_rx_d each pass through an identical 2-flop chain. A nibble is sampled on the clk cycle where synchronized rx_clk goes 0->1.
- Byte assembly: first nibble of a pair is bits [3:0], second is bits [7:4]. A rising rx_dv restarts nibble phase at low.
- FSM states: IDLE, PREAMBLE, HEADER, PAYLOAD, TRAILER, WAIT_END.
- IDLE -> PREAMBLE on sampled rx_dv=1.
- PREAMBLE: 0x55 bytes are skipped. 0xD5 -> HEADER with CRC preset to 0xFFFFFFFF. Any other byte -> WAIT_END, no drop strobe.
- HEADER: 42 bytes at offsets 0..41. All are shadowed, none committed to outputs. Checks:
  - dest MAC [0..5] == local_mac, or all-ones when ACCEPT_BROADCAST=1
  - ethertype [12..13] == 0x0800
  - [14] == 0x45
  - protocol [23] == 0x11
  - dest IP [30..33] == local_ip
  - dest port [36..37] == local_port
  - UDP length [38..39] == 8+DATA_BYTES
  - IP/UDP checksums are NOT checked.
  - Any failure sets a sticky reject flag; reception continues to frame end.
- PAYLOAD: DATA_BYTES bytes are written into a shadow payload register, byte i at [8*i+:8]. Then -> TRAILER.
- TRAILER: consumes pad and FCS bytes until rx_dv falls.
- CRC-32 (poly 0x04C11DB7, reflected, byte LSB-first) runs over every byte from offset 0 through the FCS. The frame is good iff the residue is 0xC704DD7B.
- Frame end (sampled rx_dv 1->0):
  - State TRAILER, ≥4 trailer bytes, good CRC, no reject: next clk copy shadows to data/src_*, valid=1 for one cycle.
  - Otherwise, any state past PREAMBLE: drop=1 for one cycle.
  - valid and drop are never high together.
  - Then -> IDLE.
- rx_dv falling in HEADER or PAYLOAD: drop, outputs unchanged.
- Odd trailing nibble at frame end is discarded.
- Outputs hold their values between valid strobes.
- Frames longer than 1522 bytes -> reject, drop at end.
- WAIT_END returns to IDLE when rx_dv falls, with no strobe.
- Asynchronous reset mid-frame aborts immediately; the next frame must begin with rx_dv low->high.

Test Plan:
- Good frame: dest 1a:2b:3c:4d:5e:6f / 0x11223344:0x1000, src aa:bb:cc:dd:ee:ff / 0x55667788:0x1000, payload 0x00..0x0F, 2 pad bytes, correct FCS -> valid pulses once; data[8*i+:8]=i; src_ip=0x55667788; src_mac=0xaabbccddeeff; src_port=0x1000.
- Same frame with dest port 0x1001 -> drop pulses once, valid stays 0, data unchanged from previous.
- Same frame with one payload bit flipped (FCS not updated) -> drop=1, no valid. A following good frame with payload 0xF0..0xFF -> valid, data[7:0]=0xF0.
- Dest MAC all-ones, ACCEPT_BROADCAST=1 -> valid; rerun with ACCEPT_BROADCAST=0 -> drop.
- rx_dv deasserted after payload byte 5 -> drop. The next back-to-back good frame (12-byte IFG) is accepted.
- Reset asserted mid-HEADER -> all outputs 0 immediately. A subsequent good frame -> valid.
